ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage, directly downstream of DX_reg. Consumes dx_s and produces the registered xm_s record for the memory stage.
//  Single-cycle ops (ALU, address generation) complete in one cycle. MUL runs on an iterative shift-add unit and holds the
//  pipeline via busy_o, which drives the stall input of DX_reg and the upstream registers.
// PARAMETERS
//  MUL_BPC    1   multiplier bits retired per cycle; legal values 1, 2 and 4; MUL_ITERS = 32/MUL_BPC
// PORTS
//  clk        in   1       single clock, rising edge
//  reset_n    in   1       synchronous, active-low reset
//  dx_s_i     in   dx_s    record from DX_reg (instruction, PC, rs/rd values, control bits)
//  stall_i    in   1       downstream (memory stage) stall; freezes xm_s_o and the FSM
//  flush_i    in   1       branch/exception flush; kills the op in flight
//  xm_s_o     out  xm_s    registered record to the XM stage
//  busy_o     out  1       multi-cycle op in progress; upstream must hold dx_s_i stable
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge) has priority over all other inputs.
//    Result: state=IDLE, busy_o=0, xm_s_o.instruction_xm=`kNOP, PC_r_xm=0, alu_result_xm=0, store_data_xm=0,
//    and all control bits =0.
//  - Op class comes from decode_ex_op(dx_s_i.instruction_dx) in the package: EX_ALU, EX_MEM, EX_MUL, EX_NOP.
//  - Priority order, applied every cycle: reset > flush_i > stall_i > normal operation.
//  - flush_i: state goes to IDLE, busy_o drops on the next cycle, xm_s_o is loaded with a bubble
//    (kNOP, control bits 0, PC_r_xm holds). Partial product is discarded. Flush wins over a simultaneous stall_i.
//  - stall_i (no flush): xm_s_o, the FSM state, the iteration counter and the accumulator all hold.
//  - FSM states: IDLE, MUL, DONE.
//    - IDLE, EX_ALU/EX_MEM/EX_NOP: xm_s_o is loaded 1 cycle later with the 32-bit result, wrap-around, no flags.
//      alu_result = rs op rd. For MEM the result is the address rs+rd.
//      store_data_xm = rd_val_dx. Control bits are copied from dx_s_i.
//    - IDLE, EX_MUL: latch multiplicand=rs_val and multiplier=rd_val, clear acc and cnt, go to MUL. busy_o=1 from this
//      cycle, decoded combinationally from the op class in IDLE. xm_s_o gets a bubble.
//    - MUL: each cycle add (multiplicand << k) * multiplier[MUL_BPC-1:0] into acc, shift multiplicand left by MUL_BPC,
//      shift multiplier right by MUL_BPC, cnt++. When cnt==MUL_ITERS-1, go to DONE. xm_s_o gets a bubble every MUL cycle.
//    - DONE: xm_s_o gets the low 32 bits of the product as alu_result_xm, with op_writes_rf from dx_s_i.
//      busy_o=0 in DONE so the upstream releases. Return to IDLE.
//  - MUL latency: MUL_ITERS+1 cycles from acceptance to the xm_s_o update (33 cycles for MUL_BPC=1).
//  - The product is unsigned low-32; it equals the signed low-32 product, so no sign handling is needed.
//  - dx_s_i is sampled only in IDLE and DONE. Changes on dx_s_i while in MUL are ignored.
//  - A kNOP or bubble from DX_reg (the flush/bubble path) passes through as a bubble.
// STRUCTURE
//  - definitions.sv package:
//    - xm_s typedef: instruction_xm, PC_r_xm, alu_result_xm, store_data_xm, is_load_op_c_xm, op_writes_rf_c_xm,
//      is_store_op_c_xm, is_mem_op_c_xm, is_byte_op_c_xm.
//    - ex_op_e enum and the decode_ex_op() function.
//    - ex_state_e enum {IDLE, MUL, DONE}.
//  - Sub-module iter_mul: start, abort, hold, a, b -> done, p[31:0]; owns cnt and acc.
//    ex_stage keeps the FSM sequencing and the xm register.
// TESTING
//  1. Reset: hold reset_n=0 for 2 cycles with a MUL on dx_s_i -> xm_s_o is a NOP with all control bits 0, busy_o=0.
//  2. ALU: ADD with rs=0xFFFF_FFFF, rd=2 -> next cycle alu_result_xm=0x0000_0001, op_writes_rf copied, busy_o stays 0.
//  3. MUL, MUL_BPC=1: rs=7, rd=6 -> busy_o=1 for 33 cycles, bubbles on xm_s_o, then alu_result_xm=42.
//     Rerun with MUL_BPC=4: latency 9 cycles.
//  4. MUL wrap: rs=rd=0xFFFF_FFFF -> alu_result_xm=0x0000_0001. Then rs=0x8000_0000, rd=2 -> 0x0000_0000.
//  5. flush_i at iteration 10 of a MUL, with stall_i=1 in the same cycle -> next cycle IDLE, busy_o=0, xm_s_o is a bubble.
//     A following ADD 3+4 -> 7.
//  6. stall_i=1 for 5 cycles in DONE and for 5 cycles mid-MUL -> xm_s_o and cnt frozen, product still correct (e.g. 1234*5678=7006652).
//     Also: reset_n=0 mid-MUL -> IDLE, busy_o=0.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: DX/XM records, op-class decode, FSM states.
package ex_stage_pkg;
  localparam logic [31:0] kNOP = 32'h0000_0000;

  localparam logic [5:0] OPC_NOP = 6'd0;
  localparam logic [5:0] OPC_ADD = 6'd1;
  localparam logic [5:0] OPC_SUB = 6'd2;
  localparam logic [5:0] OPC_AND = 6'd3;
  localparam logic [5:0] OPC_OR  = 6'd4;
  localparam logic [5:0] OPC_XOR = 6'd5;
  localparam logic [5:0] OPC_LW  = 6'd6;
  localparam logic [5:0] OPC_SW  = 6'd7;
  localparam logic [5:0] OPC_LB  = 6'd8;
  localparam logic [5:0] OPC_SB  = 6'd9;
  localparam logic [5:0] OPC_MUL = 6'd10;

  typedef enum logic [1:0] {EX_NOP, EX_ALU, EX_MEM, EX_MUL} ex_op_e;
  typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_e;

  typedef struct packed {
    logic [31:0] instruction_dx;
    logic [31:0] PC_r_dx;
    logic [31:0] rs_val_dx;
    logic [31:0] rd_val_dx;
    logic        is_load_op_c_dx;
    logic        op_writes_rf_c_dx;
    logic        is_store_op_c_dx;
    logic        is_mem_op_c_dx;
    logic        is_byte_op_c_dx;
  } dx_s;

  typedef struct packed {
    logic [31:0] instruction_xm;
    logic [31:0] PC_r_xm;
    logic [31:0] alu_result_xm;
    logic [31:0] store_data_xm;
    logic        is_load_op_c_xm;
    logic        op_writes_rf_c_xm;
    logic        is_store_op_c_xm;
    logic        is_mem_op_c_xm;
    logic        is_byte_op_c_xm;
  } xm_s;

  function automatic ex_op_e decode_ex_op(input logic [31:0] instr);
    case (instr[31:26])
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR: decode_ex_op = EX_ALU;
      OPC_LW, OPC_SW, OPC_LB, OPC_SB:             decode_ex_op = EX_MEM;
      OPC_MUL:                                    decode_ex_op = EX_MUL;
      default:                                    decode_ex_op = EX_NOP;
    endcase
  endfunction

  function automatic logic [31:0] alu_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    case (opc)
      OPC_SUB: alu_op = a - b;
      OPC_AND: alu_op = a & b;
      OPC_OR:  alu_op = a | b;
      OPC_XOR: alu_op = a ^ b;
      default: alu_op = a + b;
    endcase
  endfunction
endpackage

// File: rtl/ex_stage_iter_mul.sv
// Iterative shift-add multiplier, BPC multiplier bits per cycle; low 32 bits of a*b.
module iter_mul #(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        hold_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] p_o
);
  localparam int ITERS = 32 / BPC;
  localparam int CW    = $clog2(ITERS);

  logic          act_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   acc_q, mcand_q, mplier_q;
  logic [31:0]   pp;

  assign pp     = mcand_q * {{(32-BPC){1'b0}}, mplier_q[BPC-1:0]};
  assign done_o = act_q && (cnt_q == CW'(ITERS-1));
  assign p_o    = acc_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (abort_i) begin
      act_q <= 1'b0;
    end else if (!hold_i) begin
      if (start_i) begin
        act_q    <= 1'b1;
        cnt_q    <= '0;
        acc_q    <= '0;
        mcand_q  <= a_i;
        mplier_q <= b_i;
      end else if (act_q) begin
        acc_q    <= acc_q + pp;
        mcand_q  <= mcand_q << BPC;
        mplier_q <= mplier_q >> BPC;
        cnt_q    <= cnt_q + CW'(1);
        if (done_o) act_q <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/AGU into the XM register, MUL via iter_mul with busy_o holding upstream.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MUL_BPC = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  dx_s  dx_s_i,
  input  logic stall_i,
  input  logic flush_i,
  output xm_s  xm_s_o,
  output logic busy_o
);
  ex_state_e   state_q;
  xm_s         xm_q, bubble, res;
  ex_op_e      op;
  logic        mul_start, mul_done;
  logic [31:0] mul_p;

  assign op        = decode_ex_op(dx_s_i.instruction_dx);
  assign mul_start = (state_q == IDLE) && (op == EX_MUL) && !flush_i && !stall_i;
  assign busy_o    = reset_n && (((state_q == IDLE) && (op == EX_MUL)) || (state_q == MUL));
  assign xm_s_o    = xm_q;

  iter_mul #(.BPC(MUL_BPC)) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (mul_start),
    .abort_i (flush_i),
    .hold_i  (stall_i),
    .a_i     (dx_s_i.rs_val_dx),
    .b_i     (dx_s_i.rd_val_dx),
    .done_o  (mul_done),
    .p_o     (mul_p)
  );

  // Bubble keeps PC and data of the last record; only instruction and control are cleared.
  always_comb begin
    bubble                   = xm_q;
    bubble.instruction_xm    = kNOP;
    bubble.is_load_op_c_xm   = 1'b0;
    bubble.op_writes_rf_c_xm = 1'b0;
    bubble.is_store_op_c_xm  = 1'b0;
    bubble.is_mem_op_c_xm    = 1'b0;
    bubble.is_byte_op_c_xm   = 1'b0;
  end

  always_comb begin
    res.instruction_xm    = dx_s_i.instruction_dx;
    res.PC_r_xm           = dx_s_i.PC_r_dx;
    res.alu_result_xm     = (op == EX_MEM) ? dx_s_i.rs_val_dx + dx_s_i.rd_val_dx
                          : (op == EX_MUL) ? mul_p
                          : alu_op(dx_s_i.instruction_dx[31:26], dx_s_i.rs_val_dx, dx_s_i.rd_val_dx);
    res.store_data_xm     = dx_s_i.rd_val_dx;
    res.is_load_op_c_xm   = dx_s_i.is_load_op_c_dx;
    res.op_writes_rf_c_xm = dx_s_i.op_writes_rf_c_dx;
    res.is_store_op_c_xm  = dx_s_i.is_store_op_c_dx;
    res.is_mem_op_c_xm    = dx_s_i.is_mem_op_c_dx;
    res.is_byte_op_c_xm   = dx_s_i.is_byte_op_c_dx;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      xm_q    <= '0;
      xm_q.instruction_xm <= kNOP;
    end else if (flush_i) begin
      state_q <= IDLE;
      xm_q    <= bubble;
    end else if (!stall_i) begin
      case (state_q)
        IDLE: begin
          if (op == EX_MUL) begin
            state_q <= MUL;
            xm_q    <= bubble;
          end else if (op == EX_NOP) begin
            xm_q <= bubble;
          end else begin
            xm_q <= res;
          end
        end
        MUL: begin
          xm_q <= bubble;
          if (mul_done) state_q <= DONE;
        end
        DONE: begin
          xm_q    <= res;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU, MUL latency (BPC 1 and 4), wrap, flush, stall, mid-MUL reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  dx_s  dx1, dx4;
  logic stall, flush;
  logic stall4 = 1'b0, flush4 = 1'b0;
  xm_s  xm1, xm4;
  logic busy1, busy4;
  int   n_chk = 0, n_fail = 0;
  int   lat, bcnt, bad;

  always #5 clk = ~clk;

  ex_stage #(.MUL_BPC(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .dx_s_i(dx1), .stall_i(stall), .flush_i(flush),
    .xm_s_o(xm1), .busy_o(busy1));
  ex_stage #(.MUL_BPC(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .dx_s_i(dx4), .stall_i(stall4), .flush_i(flush4),
    .xm_s_o(xm4), .busy_o(busy4));

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  localparam logic [31:0] I_ADD = {OPC_ADD, 26'd0};
  localparam logic [31:0] I_MUL = {OPC_MUL, 26'd0};

  function automatic dx_s mk(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rd);
    dx_s d;
    d = '0;
    d.instruction_dx    = instr;
    d.PC_r_dx           = 32'h0000_0100;
    d.rs_val_dx         = rs;
    d.rd_val_dx         = rd;
    d.op_writes_rf_c_dx = (instr != kNOP);
    return d;
  endfunction

  function automatic logic [4:0] ctl(input xm_s x);
    return {x.is_load_op_c_xm, x.op_writes_rf_c_xm, x.is_store_op_c_xm, x.is_mem_op_c_xm, x.is_byte_op_c_xm};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one MUL on the selected DUT and measures edges to result, busy cycles and non-bubble records.
  task automatic mul_run(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bc, output int bd);
    xm_s x;
    logic bz;
    l = 0; bc = 0; bd = 0;
    if (sel) dx4 = mk(I_MUL, a, b); else dx1 = mk(I_MUL, a, b);
    #1;
    bz = sel ? busy4 : busy1;
    if (bz) bc++;
    tick();
    while (l < 60) begin
      bz = sel ? busy4 : busy1;
      if (bz) bc++;
      tick();
      l++;
      x = sel ? xm4 : xm1;
      if (x.instruction_xm == I_MUL) break;
      if (x.instruction_xm != kNOP) bd++;
    end
    if (sel) dx4 = mk(kNOP, 0, 0); else dx1 = mk(kNOP, 0, 0);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
    dx1 = mk(I_MUL, 32'd7, 32'd6);
    dx4 = mk(kNOP, 0, 0);
    tick(); tick();
    chk("rst_instr", xm1.instruction_xm, kNOP);
    chk("rst_pc",    xm1.PC_r_xm, 32'h0);
    chk("rst_alu",   xm1.alu_result_xm, 32'h0);
    chk("rst_store", xm1.store_data_xm, 32'h0);
    chk("rst_ctl",   ctl(xm1), 5'b0);
    chk("rst_busy",  busy1, 1'b0);

    dx1 = mk(I_ADD, 32'hFFFF_FFFF, 32'h2);
    reset_n = 1'b1;
    #1;
    chk("add_busy_pre", busy1, 1'b0);
    tick();
    chk("add_res",   xm1.alu_result_xm, 32'h0000_0001);
    chk("add_wr",    xm1.op_writes_rf_c_xm, 1'b1);
    chk("add_store", xm1.store_data_xm, 32'h2);
    chk("add_busy",  busy1, 1'b0);

    mul_run(1'b0, 32'd7, 32'd6, lat, bcnt, bad);
    chk("mul1_lat",    lat, 33);
    chk("mul1_busy",   bcnt, 33);
    chk("mul1_bubble", bad, 0);
    chk("mul1_res",    xm1.alu_result_xm, 32'd42);
    chk("mul1_wr",     xm1.op_writes_rf_c_xm, 1'b1);
    chk("mul1_idle",   busy1, 1'b0);

    mul_run(1'b1, 32'd7, 32'd6, lat, bcnt, bad);
    chk("mul4_lat",  lat, 9);
    chk("mul4_busy", bcnt, 9);
    chk("mul4_res",  xm4.alu_result_xm, 32'd42);

    mul_run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, bad);
    chk("wrap1_res", xm1.alu_result_xm, 32'h0000_0001);
    mul_run(1'b0, 32'h8000_0000, 32'h2, lat, bcnt, bad);
    chk("wrap2_res", xm1.alu_result_xm, 32'h0000_0000);
    mul_run(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt, bad);
    chk("wrap4_res", xm4.alu_result_xm, 32'h0000_0001);

    dx1 = mk(I_MUL, 32'd1234, 32'd5678);
    tick();
    repeat (10) tick();
    flush = 1'b1; stall = 1'b1; dx1 = mk(kNOP, 0, 0);
    tick();
    flush = 1'b0; stall = 1'b0;
    #1;
    chk("flush_busy",  busy1, 1'b0);
    chk("flush_instr", xm1.instruction_xm, kNOP);
    chk("flush_ctl",   ctl(xm1), 5'b0);
    dx1 = mk(I_ADD, 32'd3, 32'd4);
    tick();
    chk("post_flush_add", xm1.alu_result_xm, 32'd7);
    chk("post_flush_wr",  xm1.op_writes_rf_c_xm, 1'b1);
    dx1 = mk(kNOP, 0, 0);
    tick();

    dx1 = mk(I_MUL, 32'd1234, 32'd5678);
    tick();
    repeat (10) tick();
    stall = 1'b1;
    repeat (5) tick();
    chk("stall_mul_busy",  busy1, 1'b1);
    chk("stall_mul_instr", xm1.instruction_xm, kNOP);
    stall = 1'b0;
    repeat (21) tick();
    chk("stall_pre_done_busy", busy1, 1'b1);
    tick();
    chk("done_busy", busy1, 1'b0);
    stall = 1'b1;
    repeat (5) tick();
    chk("stall_done_instr", xm1.instruction_xm, kNOP);
    chk("stall_done_busy",  busy1, 1'b0);
    stall = 1'b0;
    tick();
    chk("stall_mul_res", xm1.alu_result_xm, 32'd7006652);
    dx1 = mk(kNOP, 0, 0);
    tick();

    dx1 = mk(I_MUL, 32'd9, 32'd9);
    tick();
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy_in", busy1, 1'b0);
    tick();
    reset_n = 1'b1;
    dx1 = mk(I_ADD, 32'd3, 32'd4);
    #1;
    chk("rst_mid_busy",  busy1, 1'b0);
    chk("rst_mid_instr", xm1.instruction_xm, kNOP);
    tick();
    chk("rst_mid_add", xm1.alu_result_xm, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
